// File: rtl/bresenham_ray.sv
// bresenham_ray: traces one grid ray from origin to endpoint, presenting each cell once
// and holding the current cell while the downstream stage stalls.
module bresenham_ray #(
  parameter int COORD_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               stall,
  output logic               ready,
  output logic               busy,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic               cell_we,
  output logic               cell_hit,
  output logic               done
);
  localparam int W = COORD_W + 2;
  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;
  state_t state_q;
  logic [COORD_W-1:0] x_q, y_q, x1_q, y1_q, x_d, y_d;
  logic signed [W-1:0] dx_q, dy_q, err_q, err_d, e2, adx, ady;
  logic sxn_q, syn_q, at_end, step_x, step_y;
  always_comb begin
    adx = x1_q >= x_q ? W'(x1_q - x_q) : W'(x_q - x1_q);
    ady = y1_q >= y_q ? W'(y1_q - y_q) : W'(y_q - y1_q);
    at_end = x_q == x1_q && y_q == y1_q;
    e2 = err_q <<< 1;
    step_x = e2 >= dy_q;
    step_y = e2 <= dx_q;
    err_d = err_q + (step_x ? dy_q : W'(0)) + (step_y ? dx_q : W'(0));
    x_d = step_x ? (sxn_q ? x_q - 1'b1 : x_q + 1'b1) : x_q;
    y_d = step_y ? (syn_q ? y_q - 1'b1 : y_q + 1'b1) : y_q;
  end
  // The origin is latched straight into the cell position; INIT derives deltas from it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      sxn_q <= 1'b0;
      syn_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          x_q <= x0;
          y_q <= y0;
          x1_q <= x1;
          y1_q <= y1;
          state_q <= INIT;
        end
        INIT: begin
          dx_q <= adx;
          dy_q <= -ady;
          err_q <= adx - ady;
          sxn_q <= !(x_q < x1_q);
          syn_q <= !(y_q < y1_q);
          state_q <= STEP;
        end
        STEP: if (!stall) begin
          if (at_end) state_q <= DONE;
          else begin
            x_q <= x_d;
            y_q <= y_d;
            err_q <= err_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready = state_q == IDLE;
  assign busy = !ready;
  assign cell_x = x_q;
  assign cell_y = y_q;
  assign cell_we = state_q == STEP && !stall;
  assign cell_hit = state_q == STEP && at_end;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_bresenham_ray.sv
// tb_bresenham_ray: scoreboard bench for bresenham_ray; expected cells are queued when a
// ray is launched and popped by a write monitor as the DUT emits them.
module tb_bresenham_ray;
  localparam int CW = 10;
  typedef struct packed {logic [CW-1:0] x; logic [CW-1:0] y; logic hit;} cell_t;
  logic clock = 0, reset = 1, start = 0, stall = 0;
  logic [CW-1:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  logic ready, busy, cell_we, cell_hit, done;
  logic [CW-1:0] cell_x, cell_y;
  cell_t exp_q[$];
  cell_t mon_e;
  int vectors = 0, miscompares = 0, cyc = 0;
  int n_we = 0, n_done = 0, first_we = -1, last_we = -1, done_cyc = -1, start_cyc = 0;
  bit done_seen = 0;

  bresenham_ray #(.COORD_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .stall(stall),
    .ready(ready), .busy(busy), .cell_x(cell_x), .cell_y(cell_y),
    .cell_we(cell_we), .cell_hit(cell_hit), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // write monitor: every emitted cell is checked against the head of the scoreboard
  always @(negedge clock) begin
    if (cell_we) begin
      if (n_we == 0) first_we = cyc;
      last_we = cyc;
      n_we++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cell: unexpected write (%0d,%0d) hit=%0b", cell_x, cell_y, cell_hit);
      end else begin
        mon_e = exp_q.pop_front();
        if ({cell_x, cell_y, cell_hit} !== mon_e) begin
          miscompares++;
          $display("FAIL cell: got (%0d,%0d) hit=%0b, want (%0d,%0d) hit=%0b",
                   cell_x, cell_y, cell_hit, mon_e.x, mon_e.y, mon_e.hit);
        end
      end
    end
    if (done) begin
      done_seen = 1;
      done_cyc = cyc;
      n_done++;
    end
  end

  task automatic push(input int x, input int y, input bit h);
    cell_t c;
    c.x = CW'(x);
    c.y = CW'(y);
    c.hit = h;
    exp_q.push_back(c);
  endtask

  task automatic clear();
    exp_q.delete();
    n_we = 0;
    n_done = 0;
    first_we = -1;
    last_we = -1;
    done_cyc = -1;
    done_seen = 0;
  endtask

  task automatic start_ray(input int ax, input int ay, input int bx, input int by);
    #1;
    x0 = CW'(ax);
    y0 = CW'(ay);
    x1 = CW'(bx);
    y1 = CW'(by);
    start = 1;
    @(posedge clock);
    #1;
    start = 0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(posedge clock);
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++;
    if ({ready, busy, cell_we, cell_hit, done, cell_x, cell_y} !== {5'b10000, 20'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got r=%0b b=%0b we=%0b hit=%0b d=%0b (%0d,%0d)",
               ready, busy, cell_we, cell_hit, done, cell_x, cell_y);
    end
    x0 = 3; y0 = 3; x1 = 8; y1 = 8;
    start = 1;
    @(posedge clock);
    #1;
    reset = 0;
    start = 0;
    repeat (2) begin
      @(negedge clock);
      vectors++;
      if (ready !== 1'b1 || cell_we !== 1'b0) begin
        miscompares++;
        $display("FAIL start_with_reset: got ready=%0b we=%0b, want ready=1 we=0", ready, cell_we);
      end
    end
  endtask

  task automatic test_horizontal();
    clear();
    for (int i = 2; i <= 6; i++) push(i, 5, i == 6);
    start_ray(2, 5, 6, 5);
    wait_done(20);
    repeat (2) @(posedge clock);
    vectors++;
    if (n_we != 5 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL horiz_count: got %0d writes, %0d left, want 5 and 0", n_we, exp_q.size());
    end
    vectors++;
    if (first_we - start_cyc != 1 || last_we - first_we != 4) begin
      miscompares++;
      $display("FAIL horiz_latency: first=%0d last=%0d start=%0d, want first=start+1 last=first+4",
               first_we, last_we, start_cyc);
    end
    vectors++;
    if (done_cyc - last_we != 1 || n_done != 1) begin
      miscompares++;
      $display("FAIL horiz_done: done at +%0d, %0d pulses, want +1 and 1", done_cyc - last_we, n_done);
    end
  endtask

  task automatic test_steep();
    clear();
    push(0, 0, 0); push(0, 1, 0); push(1, 2, 0); push(1, 3, 0); push(2, 4, 0); push(2, 5, 1);
    start_ray(0, 0, 2, 5);
    wait_done(20);
    vectors++;
    if (n_we != 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL steep_count: got %0d writes, %0d left, want 6 and 0", n_we, exp_q.size());
    end
  endtask

  task automatic test_shallow_neg();
    clear();
    push(5, 2, 0); push(4, 2, 0); push(3, 3, 0); push(2, 3, 0); push(1, 4, 0); push(0, 4, 1);
    start_ray(5, 2, 0, 4);
    wait_done(20);
    vectors++;
    if (n_we != 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL shallow_count: got %0d writes, %0d left, want 6 and 0", n_we, exp_q.size());
    end
  endtask

  task automatic test_diag_neg();
    clear();
    for (int i = 7; i >= 4; i--) push(i, i, i == 4);
    start_ray(7, 7, 4, 4);
    wait_done(20);
    vectors++;
    if (n_we != 4 || exp_q.size() != 0 || last_we - first_we != 3) begin
      miscompares++;
      $display("FAIL diag_count: got %0d writes span %0d, want 4 span 3", n_we, last_we - first_we);
    end
  endtask

  task automatic test_stall();
    clear();
    for (int i = 0; i <= 3; i++) push(i, 0, i == 3);
    start_ray(0, 0, 3, 0);
    fork
      wait_done(30);
      begin
        repeat (2) begin
          @(posedge clock);
          #1;
        end
        stall = 1;
        repeat (3) begin
          @(negedge clock);
          vectors++;
          if (cell_we !== 1'b0 || cell_x !== CW'(1) || cell_y !== CW'(0)) begin
            miscompares++;
            $display("FAIL stall_hold: got we=%0b (%0d,%0d), want we=0 (1,0)", cell_we, cell_x, cell_y);
          end
          @(posedge clock);
          #1;
        end
        stall = 0;
      end
    join
    vectors++;
    if (n_we != 4 || exp_q.size() != 0 || last_we - first_we != 6) begin
      miscompares++;
      $display("FAIL stall_count: got %0d writes span %0d, want 4 span 6", n_we, last_we - first_we);
    end
  endtask

  task automatic test_degenerate();
    clear();
    push(9, 9, 1);
    start_ray(9, 9, 9, 9);
    x0 = 1; y0 = 2; x1 = 3; y1 = 4;
    start = 1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    start = 0;
    wait_done(10);
    repeat (4) @(negedge clock);
    vectors++;
    if (n_we != 1 || n_done != 1 || exp_q.size() != 0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL degenerate: got %0d writes %0d dones ready=%0b, want 1 1 1", n_we, n_done, ready);
    end
    vectors++;
    if (first_we - start_cyc != 1) begin
      miscompares++;
      $display("FAIL degenerate_latency: first write at start+%0d, want start+1", first_we - start_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int la;
    clear();
    push(3, 3, 0); push(3, 2, 0); push(3, 1, 1);
    start_ray(3, 3, 3, 1);
    wait_done(20);
    la = last_we;
    n_we = 0;
    done_seen = 0;
    push(0, 0, 0); push(1, 1, 1);
    start_ray(0, 0, 1, 1);
    wait_done(20);
    repeat (2) @(posedge clock);
    vectors++;
    if (first_we - la != 4) begin
      miscompares++;
      $display("FAIL b2b_gap: next first write %0d cycles after last, want 4", first_we - la);
    end
    vectors++;
    if (n_we != 2 || n_done != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d writes %0d dones, want 2 and 2", n_we, n_done);
    end
  endtask

  task automatic test_long_diag();
    clear();
    for (int i = 0; i < 1024; i++) push(1023 - i, i, i == 1023);
    start_ray(1023, 0, 0, 1023);
    wait_done(1100);
    vectors++;
    if (n_we != 1024 || exp_q.size() != 0 || last_we - first_we != 1023) begin
      miscompares++;
      $display("FAIL long_diag: got %0d writes span %0d, want 1024 span 1023", n_we, last_we - first_we);
    end
  endtask

  task automatic test_reset_mid();
    clear();
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
    start_ray(0, 0, 10, 0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset = 1;
    @(negedge clock);
    vectors++;
    if (cell_we !== 1'b1 || cell_x !== CW'(2)) begin
      miscompares++;
      $display("FAIL mid_third: got we=%0b x=%0d, want we=1 x=2", cell_we, cell_x);
    end
    @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    vectors++;
    if ({ready, busy, cell_we, done, cell_x} !== {4'b1000, 10'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got r=%0b b=%0b we=%0b d=%0b x=%0d, want 1 0 0 0 0",
               ready, busy, cell_we, done, cell_x);
    end
    repeat (5) @(negedge clock);
    vectors++;
    if (n_we != 3 || n_done != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_abandon: got %0d writes %0d dones, want 3 and 0", n_we, n_done);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_horizontal();
    test_steep();
    test_shallow_neg();
    test_diag_neg();
    test_stall();
    test_degenerate();
    test_back_to_back();
    test_long_diag();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
